// File: rtl/tri_raster_ctrl.sv
// tri_raster_ctrl: scans a triangle's bounding box and streams the inside
// pixels, sharing one edge-function unit across the three edges.
module tri_raster_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] pt1X,
  input  logic [11:0] pt1Y,
  input  logic [11:0] pt2X,
  input  logic [11:0] pt2Y,
  input  logic [11:0] pt3X,
  input  logic [11:0] pt3Y,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] ptX,
  output logic [11:0] ptY,
  output logic [24:0] inside_cnt
);
  typedef enum logic [2:0] {
    IDLE, BBOX, EV0, EV1, EV2, OUT, DONE
  } state_e;

  state_e      state_q;
  logic [11:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic [11:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [11:0] px_q, py_q;
  logic [24:0] cnt_q;
  logic        in_q, busy_q, done_q, valid_q;

  // Edge endpoints follow the evaluation state: EV0 1->2, EV1 2->3, EV2 3->1.
  logic [11:0] ax, ay, bx, by;
  always_comb begin
    ax = v1x_q;
    ay = v1y_q;
    bx = v2x_q;
    by = v2y_q;
    case (state_q)
      EV1: begin
        ax = v2x_q; ay = v2y_q;
        bx = v3x_q; by = v3y_q;
      end
      EV2: begin
        ax = v3x_q; ay = v3y_q;
        bx = v1x_q; by = v1y_q;
      end
      default: ;
    endcase
  end

  logic signed [12:0] dpx, dpy, dbx, dby;
  logic signed [25:0] m0, m1;
  logic signed [26:0] e;
  logic               ge;

  assign dpx = {1'b0, px_q} - {1'b0, ax};
  assign dpy = {1'b0, py_q} - {1'b0, ay};
  assign dbx = {1'b0, bx} - {1'b0, ax};
  assign dby = {1'b0, by} - {1'b0, ay};
  assign m0  = 26'(dpx) * 26'(dby);
  assign m1  = 26'(dpy) * 26'(dbx);
  assign e   = 27'(m0) - 27'(m1);
  assign ge  = ~e[26];

  logic [11:0] bxmin, bxmax, bymin, bymax;
  always_comb begin
    bxmin = (v1x_q < v2x_q) ? v1x_q : v2x_q;
    bxmax = (v1x_q > v2x_q) ? v1x_q : v2x_q;
    bymin = (v1y_q < v2y_q) ? v1y_q : v2y_q;
    bymax = (v1y_q > v2y_q) ? v1y_q : v2y_q;
    if (v3x_q < bxmin) bxmin = v3x_q;
    if (v3x_q > bxmax) bxmax = v3x_q;
    if (v3y_q < bymin) bymin = v3y_q;
    if (v3y_q > bymax) bymax = v3y_q;
  end

  logic        x_end, last;
  logic [11:0] nx, ny;
  assign x_end = (px_q == xmax_q);
  assign last  = x_end && (py_q == ymax_q);
  assign nx    = x_end ? xmin_q : px_q + 12'd1;
  assign ny    = x_end ? py_q + 12'd1 : py_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      v1x_q <= '0; v1y_q <= '0;
      v2x_q <= '0; v2y_q <= '0;
      v3x_q <= '0; v3y_q <= '0;
      xmin_q <= '0; xmax_q <= '0;
      ymin_q <= '0; ymax_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      in_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            v1x_q <= pt1X; v1y_q <= pt1Y;
            v2x_q <= pt2X; v2y_q <= pt2Y;
            v3x_q <= pt3X; v3y_q <= pt3Y;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= BBOX;
          end
        end
        BBOX: begin
          xmin_q  <= bxmin;
          xmax_q  <= bxmax;
          ymin_q  <= bymin;
          ymax_q  <= bymax;
          px_q    <= bxmin;
          py_q    <= bymin;
          state_q <= EV0;
        end
        EV0: begin
          in_q    <= ge;
          state_q <= EV1;
        end
        EV1: begin
          in_q    <= in_q & ge;
          state_q <= EV2;
        end
        EV2: begin
          if (in_q & ge) begin
            cnt_q   <= cnt_q + 25'd1;
            valid_q <= 1'b1;
            state_q <= OUT;
          end else if (last) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            px_q    <= nx;
            py_q    <= ny;
            state_q <= EV0;
          end
        end
        OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              px_q    <= nx;
              py_q    <= ny;
              state_q <= EV0;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign out_valid  = valid_q;
  assign ptX        = px_q;
  assign ptY        = py_q;
  assign inside_cnt = cnt_q;
endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Bench for tri_raster_ctrl: randomized triangles and handshake stalls
// checked against a direct point-in-triangle model.
module tb_tri_raster_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] pt1X = '0, pt1Y = '0;
  logic [11:0] pt2X = '0, pt2Y = '0;
  logic [11:0] pt3X = '0, pt3Y = '0;
  logic        busy, done, out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] ptX, ptY;
  logic [24:0] inside_cnt;

  tri_raster_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .pt1X(pt1X), .pt1Y(pt1Y),
    .pt2X(pt2X), .pt2Y(pt2Y),
    .pt3X(pt3X), .pt3Y(pt3Y),
    .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready),
    .ptX(ptX), .ptY(ptY), .inside_cnt(inside_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int qx[$];
  int qy[$];
  int exp_k, exp_n;
  int vcyc;
  int ready_mode;
  int stall_left;
  int stall_seen;
  bit active = 1'b0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic longint ef(input int ax, ay, bx, by, px, py);
    return longint'(px - ax) * longint'(by - ay)
         - longint'(py - ay) * longint'(bx - ax);
  endfunction

  task automatic build(input int x1, y1, x2, y2, x3, y3);
    int xl, xh, yl, yh;
    qx.delete();
    qy.delete();
    exp_k = 0;
    xl = x1; xh = x1; yl = y1; yh = y1;
    if (x2 < xl) xl = x2;
    if (x3 < xl) xl = x3;
    if (x2 > xh) xh = x2;
    if (x3 > xh) xh = x3;
    if (y2 < yl) yl = y2;
    if (y3 < yl) yl = y3;
    if (y2 > yh) yh = y2;
    if (y3 > yh) yh = y3;
    exp_n = (xh - xl + 1) * (yh - yl + 1);
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        if (ef(x1, y1, x2, y2, x, y) >= 0 &&
            ef(x2, y2, x3, y3, x, y) >= 0 &&
            ef(x3, y3, x1, y1, x, y) >= 0) begin
          qx.push_back(x);
          qy.push_back(y);
          exp_k++;
        end
  endtask

  // Per-cycle stream check; also drives the consumer's ready.
  always @(negedge clk) begin
    if (active) begin
      case (ready_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (out_valid && ptX == 12'd2 && ptY == 12'd1 &&
              stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (out_valid) begin
        vcyc++;
        if (ptX == 12'd2 && ptY == 12'd1) stall_seen++;
        if (qx.size() == 0) begin
          chk("extra_pixel", 1, 0);
        end else begin
          chk("ptX", ptX, qx[0]);
          chk("ptY", ptY, qy[0]);
          if (out_ready) begin
            void'(qx.pop_front());
            void'(qy.pop_front());
          end
        end
      end
    end
  end

  task automatic run(input int x1, y1, x2, y2, x3, y3,
                     input int mode, input bit perturb,
                     input int lit_done);
    int cyc;
    bit got;
    build(x1, y1, x2, y2, x3, y3);
    @(negedge clk);
    pt1X = 12'(x1); pt1Y = 12'(y1);
    pt2X = 12'(x2); pt2Y = 12'(y2);
    pt3X = 12'(x3); pt3Y = 12'(y3);
    ready_mode = mode;
    stall_left = 10;
    stall_seen = 0;
    vcyc = 0;
    start = 1'b1;
    active = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (perturb && cyc == 10) begin
        pt1X = 12'($urandom_range(0, 4095));
        pt2Y = 12'($urandom_range(0, 4095));
        pt3X = 12'($urandom_range(0, 4095));
        start = 1'b1;
      end else if (perturb && cyc == 11) begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    active = 1'b0;
    out_ready = 1'b1;
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_cycle", cyc, 2 + 3 * exp_n + vcyc);
      if (lit_done >= 0) chk("done_cycle_lit", cyc, lit_done);
      chk("busy_in_done", busy, 1);
      chk("inside_cnt", inside_cnt, exp_k);
      chk("pixels_left", qx.size(), 0);
      if (mode == 2) chk("stall_cycles", stall_seen, 11);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_idle", busy, 0);
      chk("cnt_hold", inside_cnt, exp_k);
    end
  endtask

  task automatic reset_outputs_zero();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ptX", ptX, 0);
    chk("rst_ptY", ptY, 0);
    chk("rst_cnt", inside_cnt, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bx, by, n;
    repeat (2) @(negedge clk);
    reset_outputs_zero();
    rst = 1'b0;

    // Literal pins on the model itself.
    build(0, 0, 0, 4, 4, 0);
    chk("model_k_tri1", exp_k, 15);
    chk("model_n_tri1", exp_n, 25);
    chk("model_first_x", qx[0], 0);
    chk("model_first_y", qy[0], 0);
    chk("model_second_x", qx[1], 1);
    build(0, 0, 4, 0, 0, 4);
    chk("model_k_rev", exp_k, 0);

    run(0, 0, 0, 4, 4, 0, 0, 1'b0, 92);
    run(0, 0, 4, 0, 0, 4, 0, 1'b0, 77);
    run(5, 5, 5, 5, 5, 5, 0, 1'b0, 6);
    run(0, 0, 0, 4, 4, 0, 2, 1'b0, 102);
    run(0, 0, 0, 4, 4, 0, 0, 1'b1, 92);

    // Reset while a pixel is being offered.
    build(0, 0, 0, 4, 4, 0);
    @(negedge clk);
    pt1X = 12'd0; pt1Y = 12'd0;
    pt2X = 12'd0; pt2Y = 12'd4;
    pt3X = 12'd4; pt3Y = 12'd0;
    ready_mode = 0;
    vcyc = 0;
    start = 1'b1;
    active = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("saw_valid_before_rst", out_valid, 1);
    active = 1'b0;
    rst = 1'b1;
    #1 reset_outputs_zero();
    @(negedge clk);
    rst = 1'b0;
    run(0, 0, 0, 4, 4, 0, 0, 1'b0, 92);

    run(4095, 4083, 4083, 4095, 4095, 4095, 1, 1'b0, -1);
    run(4095, 4083, 4095, 4095, 4083, 4095, 1, 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      bx = $urandom_range(0, 4083);
      by = $urandom_range(0, 4083);
      run(bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
          bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
          bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
          (i % 2 == 0) ? 1 : 0, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
